// File: rtl/jt12_ch_mixer.sv
// Channel mixer for the JT12 accumulator stream: captures each FM channel's left/right
// value in its slot and emits one saturated stereo sample per frame, flagging malformed frames.
module jt12_ch_mixer #(
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        zero,
    input  logic        in_valid,
    input  logic [2:0]  in_ch,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic [5:0]  ch_mute,
    output logic [15:0] snd_left,
    output logic [15:0] snd_right,
    output logic        sample,
    output logic        frame_err
);

    typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r, state_n;
    logic signed [18:0] acc_l_r, acc_l_n, acc_r_r, acc_r_n;
    logic [5:0]         seen_r, seen_n;
    logic               err_r, err_n;
    logic [15:0]        snd_l_r, snd_l_n, snd_r_r, snd_r_n;
    logic               sample_r, sample_n;
    logic               ferr_r, ferr_n;

    logic [5:0]         ch_oh_s;
    logic               ch_bad_s;
    logic               mute_hit_s;
    logic signed [18:0] in_l_ext_s, in_r_ext_s;
    logic signed [18:0] shl_l_s, shl_r_s;

    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767) begin
            sat16 = 16'h7FFF;
        end else if (v < -19'sd32768) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    // Channel 6/7 shift out of the one-hot, so illegal slots never touch seen or mute.
    assign ch_oh_s    = 6'd1 << in_ch;
    assign ch_bad_s   = (in_ch > 3'd5);
    assign mute_hit_s = |(ch_mute & ch_oh_s);
    assign in_l_ext_s = {{3{in_left[15]}}, in_left};
    assign in_r_ext_s = {{3{in_right[15]}}, in_right};
    assign shl_l_s    = acc_l_r >>> SHIFT;
    assign shl_r_s    = acc_r_r >>> SHIFT;

    // Next-state and datapath update; a slot arriving with zero lands in the fresh frame.
    always_comb begin
        state_n  = state_r;
        acc_l_n  = acc_l_r;
        acc_r_n  = acc_r_r;
        seen_n   = seen_r;
        err_n    = err_r;
        snd_l_n  = snd_l_r;
        snd_r_n  = snd_r_r;
        ferr_n   = ferr_r;
        sample_n = 1'b0;
        if (clk_en) begin
            case (state_r)
                ST_SYNC: begin
                    if (zero) begin
                        state_n = ST_RUN;
                        acc_l_n = 19'sd0;
                        acc_r_n = 19'sd0;
                        seen_n  = 6'd0;
                        err_n   = 1'b0;
                    end else begin
                        state_n = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    if (zero) begin
                        snd_l_n  = sat16(shl_l_s);
                        snd_r_n  = sat16(shl_r_s);
                        ferr_n   = err_r | (seen_r != 6'h3F);
                        sample_n = 1'b1;
                        acc_l_n  = 19'sd0;
                        acc_r_n  = 19'sd0;
                        seen_n   = 6'd0;
                        err_n    = 1'b0;
                    end else begin
                        state_n = ST_RUN;
                    end
                    if (in_valid) begin
                        if (ch_bad_s) begin
                            err_n = 1'b1;
                        end else if (|(seen_n & ch_oh_s)) begin
                            err_n = 1'b1;
                        end else begin
                            seen_n = seen_n | ch_oh_s;
                            if (!mute_hit_s) begin
                                acc_l_n = acc_l_n + in_l_ext_s;
                                acc_r_n = acc_r_n + in_r_ext_s;
                            end else begin
                                acc_l_n = acc_l_n;
                                acc_r_n = acc_r_n;
                            end
                        end
                    end else begin
                        err_n = err_n;
                    end
                end
                default: begin
                    state_n = ST_SYNC;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_n;
        end
    end

    // Accumulators, frame bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_l_r  <= 19'sd0;
            acc_r_r  <= 19'sd0;
            seen_r   <= 6'd0;
            err_r    <= 1'b0;
            snd_l_r  <= 16'd0;
            snd_r_r  <= 16'd0;
            sample_r <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            acc_l_r  <= acc_l_n;
            acc_r_r  <= acc_r_n;
            seen_r   <= seen_n;
            err_r    <= err_n;
            snd_l_r  <= snd_l_n;
            snd_r_r  <= snd_r_n;
            sample_r <= sample_n;
            ferr_r   <= ferr_n;
        end
    end

    assign snd_left  = snd_l_r;
    assign snd_right = snd_r_r;
    assign sample    = sample_r;
    assign frame_err = ferr_r;

endmodule

// File: tb/tb_jt12_ch_mixer.sv
// Directed bench for jt12_ch_mixer; three instances share stimulus to cover SHIFT=0/2/3.
module tb_jt12_ch_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        zero;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [15:0] in_left, in_right;
    logic [5:0]  ch_mute;
    logic [15:0] snd_left, snd_right, snd_left2, snd_right2, snd_left3, snd_right3;
    logic        sample, sample2, sample3;
    logic        frame_err, frame_err2, frame_err3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jt12_ch_mixer #(.SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .in_valid(in_valid),
        .in_ch(in_ch), .in_left(in_left), .in_right(in_right), .ch_mute(ch_mute),
        .snd_left(snd_left), .snd_right(snd_right), .sample(sample), .frame_err(frame_err));

    jt12_ch_mixer #(.SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .in_valid(in_valid),
        .in_ch(in_ch), .in_left(in_left), .in_right(in_right), .ch_mute(ch_mute),
        .snd_left(snd_left2), .snd_right(snd_right2), .sample(sample2), .frame_err(frame_err2));

    jt12_ch_mixer #(.SHIFT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .in_valid(in_valid),
        .in_ch(in_ch), .in_left(in_left), .in_right(in_right), .ch_mute(ch_mute),
        .snd_left(snd_left3), .snd_right(snd_right3), .sample(sample3), .frame_err(frame_err3));

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int l, input int r);
        clk_en   = 1'b1;
        in_valid = 1'b1;
        in_ch    = ch[2:0];
        in_left  = l[15:0];
        in_right = r[15:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic close_frame();
        clk_en = 1'b1;
        zero   = 1'b1;
        tick();
        zero   = 1'b0;
    endtask

    // Called right after a frame-closing edge: checks outputs and the single-cycle strobe.
    task automatic expect_frame(input string tag, input int l, input int r, input int fe);
        check({tag, "_sample"}, int'(sample), 1);
        check({tag, "_left"}, int'($signed(snd_left)), l);
        check({tag, "_right"}, int'($signed(snd_right)), r);
        check({tag, "_ferr"}, int'(frame_err), fe);
        tick();
        check({tag, "_sample_drop"}, int'(sample), 0);
        check({tag, "_hold"}, int'($signed(snd_left)), l);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; zero = 1'b0; in_valid = 1'b0;
        in_ch = 3'd0; in_left = 16'd0; in_right = 16'd0; ch_mute = 6'd0;
        tick(); tick();
        check("rst_left", int'(snd_left), 0);
        check("rst_right", int'(snd_right), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_ferr", int'(frame_err), 0);
        rst_n = 1'b1;
        tick();

        // First zero only synchronises.
        close_frame();
        check("sync_no_sample", int'(sample), 0);
        for (int c = 0; c < 6; c++) send(c, 100, -100);
        close_frame();
        expect_frame("basic", 600, -600, 0);

        // Saturation at three shift settings.
        for (int c = 0; c < 6; c++) send(c, 30000, -30000);
        close_frame();
        check("sat2_left", int'($signed(snd_left2)), 32767);
        check("sat2_right", int'($signed(snd_right2)), -32768);
        check("sh3_left", int'($signed(snd_left3)), 22500);
        check("sh3_right", int'($signed(snd_right3)), -22500);
        check("sh3_sample", int'(sample3), 1);
        expect_frame("sat0", 32767, -32768, 0);

        // Muted channels 0 and 2 still count as seen.
        ch_mute = 6'b000101;
        for (int c = 0; c < 6; c++) send(c, 1000, 1000);
        close_frame();
        expect_frame("mute", 4000, 4000, 0);
        ch_mute = 6'd0;

        // Duplicate ch2 (first wins) and missing ch5.
        send(0, 1000, 10); send(1, 1000, 10); send(2, 1000, 10);
        send(2, 5000, 500); send(3, 1000, 10); send(4, 1000, 10);
        close_frame();
        expect_frame("dup", 5000, 50, 1);

        // Full frame plus an illegal channel-7 slot.
        for (int c = 0; c < 6; c++) send(c, 1, 2);
        send(7, 500, 500);
        close_frame();
        expect_frame("ch7", 6, 12, 1);

        // Slot coincident with zero belongs to the new frame.
        for (int c = 0; c < 6; c++) send(c, 10, 10);
        clk_en = 1'b1; zero = 1'b1; in_valid = 1'b1;
        in_ch = 3'd0; in_left = 16'd7; in_right = 16'hFFF9;
        tick();
        zero = 1'b0; in_valid = 1'b0;
        expect_frame("coinc_close", 60, 60, 0);
        for (int c = 1; c < 6; c++) send(c, 1, 1);
        close_frame();
        expect_frame("coinc_next", 12, -2, 0);

        // Back-to-back zero: empty frame.
        close_frame();
        expect_frame("empty", 0, 0, 1);

        // clk_en low freezes capture and frame close.
        clk_en = 1'b0; in_valid = 1'b1; zero = 1'b1; in_ch = 3'd0; in_left = 16'd999;
        tick(); tick(); tick();
        check("freeze_sample", int'(sample), 0);
        in_valid = 1'b0; zero = 1'b0;
        for (int c = 0; c < 6; c++) send(c, 1, 1);
        close_frame();
        expect_frame("freeze", 6, 6, 0);

        // Reset mid-frame with clk_en low in between.
        send(0, 100, 100); send(1, 100, 100); send(2, 100, 100);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_left", int'(snd_left), 0);
        check("midrst_right", int'(snd_right), 0);
        tick();
        rst_n = 1'b1;
        tick();
        close_frame();
        check("midrst_sync", int'(sample), 0);
        for (int c = 0; c < 6; c++) send(c, 5, 5);
        close_frame();
        expect_frame("after_rst", 30, 30, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
